sr_drive_ctrl: RTL

Upstream driver for the NOR-based SR latch. It takes two raw push-button inputs (set and reset), synchronizes and debounces them, and converts their rising edges into clean, fixed-width, mutually exclusive S and R pulses. It also reads back the latch Q output to confirm that each pulse took effect. The block guarantees the latch never sees S=R=1 and never sees a pulse narrower than PULSE_CYCLES clocks.

---
 rtl/sr_pkg.sv | 18 +
 rtl/btn_debounce.sv | 47 ++++
 rtl/sr_drive_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/sr_pkg.sv
// Shared types and default constants for the SR latch driver.
// Imported by the debounce sub-module and the top.
package sr_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SET_P,
    ST_RST_P,
    ST_GAP
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_PULSE_CYCLES    = 2;
  localparam int DEF_GAP_CYCLES      = 2;
  localparam int DEF_CNT_W           = 8;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus counter debounce for one push button.
// o_rise is high for the single cycle after the debounced level goes 0->1.
module btn_debounce
  import sr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_rise
);

  localparam logic [CNT_W-1:0] L_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_db;
  logic             r_db_q;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_db_q  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_db_q  <= r_db;
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == L_LAST) begin
        r_db  <= ~r_db;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_rise = r_db & ~r_db_q;

endmodule

// File: rtl/sr_drive_ctrl.sv
// Drives a NOR SR latch with clean, exclusive S/R pulses from two buttons
// and verifies the latch Q after each pulse.
module sr_drive_ctrl
  import sr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
  parameter int GAP_CYCLES      = DEF_GAP_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_btn,
  input  logic reset_btn,
  input  logic q_fb,
  output logic S,
  output logic R,
  output logic busy,
  output logic conflict,
  output logic dropped,
  output logic err
);

  // INIT also counts the cycle spent in reset, hence one extra count.
  localparam logic [CNT_W-1:0] L_INIT_LAST  = CNT_W'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] L_PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  logic             w_set_rise;
  logic             w_rst_rise;
  logic             w_any_rise;
  logic             w_both_rise;
  state_t           w_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_exp_nxt;
  logic             w_chk;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_exp;
  logic             r_s;
  logic             r_r;
  logic             r_busy;
  logic             r_conflict;
  logic             r_dropped;
  logic             r_err;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_db_set (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (set_btn),
    .o_rise (w_set_rise)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_db_rst (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (reset_btn),
    .o_rise (w_rst_rise)
  );

  assign w_any_rise  = w_set_rise | w_rst_rise;
  assign w_both_rise = w_set_rise & w_rst_rise;

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt + 1'b1;
    w_exp_nxt = r_exp;
    w_chk     = 1'b0;
    unique case (r_state)
      ST_INIT: begin
        if (r_cnt == L_INIT_LAST) begin
          w_nxt     = ST_GAP;
          w_cnt_nxt = '0;
          w_exp_nxt = 1'b0;
        end
      end
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_set_rise && !w_rst_rise) begin
          w_nxt = ST_SET_P;
        end else if (w_rst_rise && !w_set_rise) begin
          w_nxt = ST_RST_P;
        end
      end
      ST_SET_P: begin
        if (r_cnt == L_PULSE_LAST) begin
          w_nxt     = ST_GAP;
          w_cnt_nxt = '0;
          w_exp_nxt = 1'b1;
        end
      end
      ST_RST_P: begin
        if (r_cnt == L_PULSE_LAST) begin
          w_nxt     = ST_GAP;
          w_cnt_nxt = '0;
          w_exp_nxt = 1'b0;
        end
      end
      ST_GAP: begin
        if (r_cnt == L_GAP_LAST) begin
          w_nxt     = ST_IDLE;
          w_cnt_nxt = '0;
          w_chk     = 1'b1;
        end
      end
      default: begin
        w_nxt     = ST_INIT;
        w_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_cnt      <= '0;
      r_exp      <= 1'b0;
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_busy     <= 1'b0;
      r_conflict <= 1'b0;
      r_dropped  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_cnt      <= w_cnt_nxt;
      r_exp      <= w_exp_nxt;
      // Outputs decode the next state so they line up with r_state.
      r_s        <= (w_nxt == ST_SET_P);
      r_r        <= (w_nxt == ST_INIT) || (w_nxt == ST_RST_P);
      r_busy     <= (w_nxt != ST_IDLE);
      r_conflict <= (r_state == ST_IDLE) && w_both_rise;
      r_dropped  <= (r_state != ST_IDLE) && w_any_rise;
      if (w_chk && (q_fb != r_exp)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign S        = r_s;
  assign R        = r_r;
  assign busy     = r_busy;
  assign conflict = r_conflict;
  assign dropped  = r_dropped;
  assign err      = r_err;

endmodule
